// File: rtl/msx_bank_mapper_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msx_bank_mapper_gen                                                        |
// | MSX cartridge mapper: four 8 KB windows, delayed bank commits, JEDEC       |
// | program tracking. Optional MRAM window selected by macro MRAM_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module msx_bank_mapper_gen #(
  parameter int BANK_BITS    = 4,
  parameter int COMMIT_DELAY = 1,
  parameter int BUSY_CYCLES  = 12,
  parameter int BANK0_WR     = 0
) (
  input  logic                 SLT_CLOCK,
  input  logic                 SLT_RESET,
  input  logic                 SLT_SLTSL,
  input  logic                 SLT_WEn,
  input  logic                 SLT_RDn,
  input  logic [3:0]           SLT_A,
  input  logic [7:0]           SLT_D,
  input  logic                 SW_ROMenable,
  output logic [BANK_BITS-1:0] ROM_BA,
  output logic                 ROM_CEn,
  output logic                 ROM_OEn,
  output logic                 ROM_WEn,
  output logic                 FRAM_CEn,
  output logic                 ROM_BUSY
);

  localparam logic [2:0] c_delay = 3'(COMMIT_DELAY);
  localparam logic [7:0] c_busy  = 8'(BUSY_CYCLES);
  localparam logic       c_b0_wr = (BANK0_WR != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_U1   = 3'd1,
    S_U2   = 3'd2,
    S_PGM  = 3'd3,
    S_BUSY = 3'd4
  } flash_state_t;

  flash_state_t         r_state, w_state_nx;
  logic [7:0]           r_bcnt, w_bcnt_nx;
  logic                 r_wr_d;
  logic [BANK_BITS-1:0] r_bank [4];
  logic                 r_pend;
  logic [BANK_BITS-1:0] r_pend_val;
  logic [1:0]           r_pend_win;
  logic [2:0]           r_dcnt;
  logic                 r_flash_mode;
  logic                 w_ram_sel;
  logic                 w_ramhit;

  logic       w_sel, w_wr, w_wr_rise, w_inwin, w_ctl, w_win_ok, w_capture;
  logic       w_busy, w_fsm_wr;
  logic [1:0] w_win;
  logic       w_unused_bits;

  assign w_sel     = ~SLT_SLTSL & SW_ROMenable;
  assign w_wr      = w_sel & ~SLT_WEn;
  assign w_wr_rise = w_wr & ~r_wr_d;
  // 4000h-BFFFh: A15^A14 set; window index is {A15, A13}
  assign w_inwin   = SLT_A[3] ^ SLT_A[2];
  assign w_win     = {SLT_A[3], SLT_A[1]};
  assign w_ctl     = ~SLT_A[0];
  assign w_win_ok  = (w_win != 2'd0) | (c_b0_wr & ~r_flash_mode);
  assign w_capture = w_wr_rise & w_inwin & w_ctl & w_win_ok;
  assign w_busy    = (r_state == S_BUSY);
  assign w_fsm_wr  = w_wr_rise & w_inwin & (w_win == 2'd0) & r_flash_mode;
  assign w_unused_bits = ^{SLT_D};

  always_ff @(posedge SLT_CLOCK) begin
    if (SLT_RESET) begin
      r_wr_d       <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_val   <= '0;
      r_pend_win   <= 2'd0;
      r_dcnt       <= 3'd0;
      r_flash_mode <= 1'b0;
      for (int i = 0; i < 4; i++) r_bank[i] <= BANK_BITS'(i);
    end else begin
      r_wr_d <= w_wr;
      if (w_capture) begin
        // zero delay commits on the capture edge unless the Flash is busy
        if ((c_delay == 3'd0) && !w_busy) begin
          r_bank[w_win] <= SLT_D[BANK_BITS-1:0];
          r_pend        <= 1'b0;
        end else begin
          r_pend <= 1'b1;
        end
        r_pend_val <= SLT_D[BANK_BITS-1:0];
        r_pend_win <= w_win;
        r_dcnt     <= c_delay;
        if (w_win == 2'd3) r_flash_mode <= SLT_D[7];
      end else if (r_pend && !w_busy && (r_dcnt <= 3'd1)) begin
        r_bank[r_pend_win] <= r_pend_val;
        r_pend             <= 1'b0;
        r_dcnt             <= 3'd0;
      end else if (!w_busy && (r_dcnt != 3'd0)) begin
        r_dcnt <= r_dcnt - 3'd1;
      end
    end
  end

`ifdef MRAM_EN
  logic r_ram_sel;
  always_ff @(posedge SLT_CLOCK) begin
    if (SLT_RESET)
      r_ram_sel <= 1'b0;
    else if (w_capture && (w_win == 2'd3))
      r_ram_sel <= SLT_D[6];
  end
  assign w_ram_sel = r_ram_sel;
  // writes to the A000h-AFFFh control region never reach MRAM
  assign w_ramhit  = w_ram_sel & w_inwin & (w_win == 2'd3) & (SLT_A[0] | SLT_WEn);
  assign ROM_CEn   = ~w_sel | ~w_inwin | w_ramhit;
  assign FRAM_CEn  = ~(w_sel & w_ramhit);
`else
  assign w_ram_sel = 1'b0;
  assign w_ramhit  = w_ram_sel;
  assign ROM_CEn   = ~w_sel | ~w_inwin;
  assign FRAM_CEn  = 1'b1 | w_ramhit;
`endif

  assign ROM_WEn  = SLT_WEn;
  assign ROM_OEn  = SLT_RDn | ~w_inwin;
  assign ROM_BUSY = w_busy;

  always_comb begin
    ROM_BA = '0;
    if (w_inwin) begin
      if (r_flash_mode && (w_win == 2'd0))
        ROM_BA = SLT_A[0] ? BANK_BITS'(2) : BANK_BITS'(1);
      else
        ROM_BA = r_bank[w_win];
    end
  end

  always_ff @(posedge SLT_CLOCK) begin
    if (SLT_RESET) begin
      r_state <= S_IDLE;
      r_bcnt  <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_bcnt  <= w_bcnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_bcnt_nx  = r_bcnt;
    if ((r_state != S_IDLE) && !r_flash_mode) begin
      w_state_nx = S_IDLE;
      w_bcnt_nx  = 8'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_fsm_wr && (SLT_D == 8'hAA) && (SLT_A == 4'h5)) w_state_nx = S_U1;
        S_U1:   if (w_fsm_wr) w_state_nx = ((SLT_D == 8'h55) && (SLT_A == 4'h4)) ? S_U2 : S_IDLE;
        S_U2:   if (w_fsm_wr) w_state_nx = (SLT_D == 8'hA0) ? S_PGM : S_IDLE;
        S_PGM: begin
          // the program data write may land in any window
          if (w_wr_rise && w_inwin) begin
            w_state_nx = S_BUSY;
            w_bcnt_nx  = c_busy;
          end
        end
        S_BUSY: begin
          if (r_bcnt <= 8'd1) begin
            w_state_nx = S_IDLE;
            w_bcnt_nx  = 8'd0;
          end else begin
            w_bcnt_nx = r_bcnt - 8'd1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msx_bank_mapper_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_msx_bank_mapper_gen                                                     |
// | Directed bench for msx_bank_mapper_gen (default parameters).               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_msx_bank_mapper_gen;

`ifdef MRAM_EN
  localparam bit c_mram = 1'b1;
`else
  localparam bit c_mram = 1'b0;
`endif

  logic       SLT_CLOCK = 1'b0;
  logic       SLT_RESET = 1'b1;
  logic       SLT_SLTSL = 1'b1;
  logic       SLT_WEn   = 1'b1;
  logic       SLT_RDn   = 1'b1;
  logic [3:0] SLT_A     = 4'h0;
  logic [7:0] SLT_D     = 8'h00;
  logic       SW_ROMenable = 1'b1;
  logic [3:0] ROM_BA;
  logic       ROM_CEn, ROM_OEn, ROM_WEn, FRAM_CEn, ROM_BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  msx_bank_mapper_gen dut (
    .SLT_CLOCK(SLT_CLOCK), .SLT_RESET(SLT_RESET), .SLT_SLTSL(SLT_SLTSL),
    .SLT_WEn(SLT_WEn), .SLT_RDn(SLT_RDn), .SLT_A(SLT_A), .SLT_D(SLT_D),
    .SW_ROMenable(SW_ROMenable), .ROM_BA(ROM_BA), .ROM_CEn(ROM_CEn),
    .ROM_OEn(ROM_OEn), .ROM_WEn(ROM_WEn), .FRAM_CEn(FRAM_CEn), .ROM_BUSY(ROM_BUSY)
  );

  always #5 SLT_CLOCK = ~SLT_CLOCK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic idle_bus();
    SLT_SLTSL = 1'b1; SLT_WEn = 1'b1; SLT_RDn = 1'b1;
  endtask

  task automatic set_read(input logic [3:0] a);
    @(negedge SLT_CLOCK);
    SLT_A = a; SLT_SLTSL = 1'b0; SLT_RDn = 1'b0; SLT_WEn = 1'b1;
    #1;
  endtask

  // one-clock write strobe followed by one idle clock
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge SLT_CLOCK);
    SLT_A = a; SLT_D = d; SLT_RDn = 1'b1; SLT_SLTSL = 1'b0; SLT_WEn = 1'b0;
    @(negedge SLT_CLOCK);
    SLT_WEn = 1'b1; SLT_SLTSL = 1'b1;
    @(negedge SLT_CLOCK);
  endtask

  task automatic test_reset();
    logic [3:0] a;
    SLT_RESET = 1'b1;
    repeat (2) @(negedge SLT_CLOCK);
    SLT_RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 4'(4 + 2 * i);
      set_read(a);
      n_checks++;
      if (ROM_BA !== 4'(i)) begin n_fail++; $display("FAIL reset_bank%0d: ROM_BA=%0h expected %0h", i, ROM_BA, i); end
      n_checks++;
      if ({ROM_CEn, ROM_OEn, FRAM_CEn, ROM_BUSY} !== 4'b0010) begin
        n_fail++; $display("FAIL reset_ctl%0d: CEn/OEn/FRAM/BUSY=%b expected 0010", i, {ROM_CEn, ROM_OEn, FRAM_CEn, ROM_BUSY});
      end
    end
    set_read(4'hC);
    n_checks++;
    if ({ROM_BA, ROM_CEn, ROM_OEn} !== 6'b0000_11) begin
      n_fail++; $display("FAIL outside_window: BA/CEn/OEn=%b expected 000011", {ROM_BA, ROM_CEn, ROM_OEn});
    end
    SW_ROMenable = 1'b0;
    set_read(4'h4);
    n_checks++;
    if (ROM_CEn !== 1'b1) begin n_fail++; $display("FAIL romenable_mask: ROM_CEn=%b expected 1", ROM_CEn); end
    SW_ROMenable = 1'b1;
    idle_bus();
  endtask

  task automatic test_commit_delay();
    @(negedge SLT_CLOCK);
    SLT_A = 4'h6; SLT_D = 8'h05; SLT_RDn = 1'b1; SLT_SLTSL = 1'b0; SLT_WEn = 1'b0;
    @(negedge SLT_CLOCK); #1;
    n_checks++;
    if (ROM_BA !== 4'h1) begin n_fail++; $display("FAIL commit_early: ROM_BA=%0h expected 1", ROM_BA); end
    SLT_D = 8'h09;
    @(negedge SLT_CLOCK); #1;
    n_checks++;
    if (ROM_BA !== 4'h5) begin n_fail++; $display("FAIL commit_2edges: ROM_BA=%0h expected 5", ROM_BA); end
    @(negedge SLT_CLOCK);
    idle_bus();
    @(negedge SLT_CLOCK); #1;
    n_checks++;
    if (ROM_BA !== 4'h5) begin n_fail++; $display("FAIL single_capture: ROM_BA=%0h expected 5", ROM_BA); end
    bus_write(4'h4, 8'h03);
    bus_write(4'hC, 8'h07);
    set_read(4'h4);
    n_checks++;
    if (ROM_BA !== 4'h0) begin n_fail++; $display("FAIL bank0_locked: ROM_BA=%0h expected 0", ROM_BA); end
    set_read(4'h8);
    n_checks++;
    if (ROM_BA !== 4'h2) begin n_fail++; $display("FAIL bank2_untouched: ROM_BA=%0h expected 2", ROM_BA); end
    idle_bus();
  endtask

  task automatic test_flash_program();
    int busy_cnt, fall_k, commit_k;
    bus_write(4'hA, 8'h80);
    set_read(4'h4);
    n_checks++;
    if (ROM_BA !== 4'h1) begin n_fail++; $display("FAIL flash_win0_lo: ROM_BA=%0h expected 1", ROM_BA); end
    set_read(4'h5);
    n_checks++;
    if (ROM_BA !== 4'h2) begin n_fail++; $display("FAIL flash_win0_hi: ROM_BA=%0h expected 2", ROM_BA); end
    set_read(4'hA);
    n_checks++;
    if (ROM_BA !== 4'h0) begin n_fail++; $display("FAIL bank3_from_80: ROM_BA=%0h expected 0", ROM_BA); end
    idle_bus();
    bus_write(4'h5, 8'hAA);
    bus_write(4'h4, 8'h55);
    bus_write(4'h5, 8'hA0);
    n_checks++;
    if (ROM_BUSY !== 1'b0) begin n_fail++; $display("FAIL busy_before_pgm: ROM_BUSY=%b expected 0", ROM_BUSY); end
    @(negedge SLT_CLOCK);
    SLT_A = 4'h6; SLT_D = 8'h03; SLT_SLTSL = 1'b0; SLT_WEn = 1'b0;
    busy_cnt = 0; fall_k = 0; commit_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge SLT_CLOCK); #1;
      if (ROM_BUSY === 1'b1) busy_cnt++;
      else if (fall_k == 0) fall_k = k;
      if ((ROM_BA === 4'h7) && (commit_k == 0)) commit_k = k;
      if (k == 1 || k == 3) idle_bus();
      if (k == 2) begin SLT_A = 4'h8; SLT_D = 8'h07; SLT_SLTSL = 1'b0; SLT_WEn = 1'b0; end
    end
    n_checks++;
    if (busy_cnt != 12) begin n_fail++; $display("FAIL busy_length: %0d clocks expected 12", busy_cnt); end
    n_checks++;
    if (fall_k != 13) begin n_fail++; $display("FAIL busy_fall: clock %0d expected 13", fall_k); end
    n_checks++;
    if (commit_k != 14) begin n_fail++; $display("FAIL commit_after_busy: clock %0d expected 14", commit_k); end
    set_read(4'h6);
    n_checks++;
    if (ROM_BA !== 4'h5) begin n_fail++; $display("FAIL pending_overwritten: ROM_BA=%0h expected 5", ROM_BA); end
    idle_bus();
  endtask

  task automatic test_flash_abort();
    bus_write(4'h5, 8'hAA);
    bus_write(4'h4, 8'h12);
    bus_write(4'h5, 8'hA0);
    bus_write(4'h5, 8'h00);
    n_checks++;
    if (ROM_BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_no_busy: ROM_BUSY=%b expected 0", ROM_BUSY); end
  endtask

  task automatic test_mram();
    bus_write(4'hA, 8'h40);
    set_read(4'hB);
    n_checks++;
    if ({FRAM_CEn, ROM_CEn} !== (c_mram ? 2'b01 : 2'b10)) begin
      n_fail++; $display("FAIL mram_read_b000: FRAM_CEn/ROM_CEn=%b expected %b", {FRAM_CEn, ROM_CEn}, c_mram ? 2'b01 : 2'b10);
    end
    set_read(4'hA);
    n_checks++;
    if (FRAM_CEn !== !c_mram) begin n_fail++; $display("FAIL mram_read_a000: FRAM_CEn=%b expected %b", FRAM_CEn, !c_mram); end
    @(negedge SLT_CLOCK);
    SLT_A = 4'hA; SLT_D = 8'h42; SLT_RDn = 1'b1; SLT_SLTSL = 1'b0; SLT_WEn = 1'b0;
    #1;
    n_checks++;
    if ({FRAM_CEn, ROM_CEn} !== 2'b10) begin
      n_fail++; $display("FAIL mram_write_a000: FRAM_CEn/ROM_CEn=%b expected 10", {FRAM_CEn, ROM_CEn});
    end
    @(negedge SLT_CLOCK);
    idle_bus();
    @(negedge SLT_CLOCK);
    set_read(4'hA);
    n_checks++;
    if (ROM_BA !== 4'h2) begin n_fail++; $display("FAIL mram_reg_capture: ROM_BA=%0h expected 2", ROM_BA); end
    set_read(4'h4);
    n_checks++;
    if (ROM_BA !== 4'h0) begin n_fail++; $display("FAIL flash_mode_off: ROM_BA=%0h expected 0", ROM_BA); end
    idle_bus();
  endtask

  task automatic test_reset_busy();
    logic [3:0] a;
    bus_write(4'hA, 8'h80);
    bus_write(4'h5, 8'hAA);
    bus_write(4'h4, 8'h55);
    bus_write(4'h5, 8'hA0);
    @(negedge SLT_CLOCK);
    SLT_A = 4'h6; SLT_D = 8'h09; SLT_SLTSL = 1'b0; SLT_WEn = 1'b0;
    @(negedge SLT_CLOCK); #1;
    idle_bus();
    n_checks++;
    if (ROM_BUSY !== 1'b1) begin n_fail++; $display("FAIL busy_before_reset: ROM_BUSY=%b expected 1", ROM_BUSY); end
    @(negedge SLT_CLOCK);
    SLT_RESET = 1'b1;
    @(negedge SLT_CLOCK); #1;
    SLT_RESET = 1'b0;
    n_checks++;
    if (ROM_BUSY !== 1'b0) begin n_fail++; $display("FAIL busy_after_reset: ROM_BUSY=%b expected 0", ROM_BUSY); end
    repeat (3) @(negedge SLT_CLOCK);
    for (int i = 0; i < 4; i++) begin
      a = 4'(4 + 2 * i);
      set_read(a);
      n_checks++;
      if (ROM_BA !== 4'(i)) begin n_fail++; $display("FAIL reset_busy_bank%0d: ROM_BA=%0h expected %0h", i, ROM_BA, i); end
    end
    set_read(4'hB);
    n_checks++;
    if (FRAM_CEn !== 1'b1) begin n_fail++; $display("FAIL reset_ram_sel: FRAM_CEn=%b expected 1", FRAM_CEn); end
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_commit_delay();
    test_flash_program();
    test_flash_abort();
    test_mram();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msx_bank_mapper_gen.md
# msx_bank_mapper_gen

Parametrised MSX cartridge bank controller driving Flash ROM and optional MRAM from the slot bus. It maps four 8 KB windows (4000h–BFFFh) through per-window bank registers with edge-qualified writes and a programmable commit delay. A JEDEC program-sequence tracker holds register commits while the Flash is busy. It sits between the MSX slot connector and the ROM/MRAM chip selects, in place of the fixed 4-bank controller.

## Interface
- BANK_BITS, 4: bank register width, 2..6; ROM_BA spans [BANK_BITS+12:13].
- COMMIT_DELAY, 1: clocks from write capture to bank-register commit, 0..7.
- BUSY_CYCLES, 12: clocks ROM_BUSY stays high after a Flash program write, 1..255.
- BANK0_WR, 0: 1 makes the window-0 register writable at 4000h–4FFFh when Flash mode is off.
- SLT_CLOCK  in  1  slot clock; only clock.
- SLT_RESET  in  1  synchronous, active-high reset.
- SLT_SLTSL  in  1  slot select, active low.
- SLT_WEn, SLT_RDn  in  1  bus strobes, active low.
- SLT_A  in  4  address bits [15:12].
- SLT_D  in  8  write data.
- SW_ROMenable  in  1  high enables the cartridge; low masks SLTSL.
- ROM_BA  out  BANK_BITS  bank address to Flash/MRAM.
- ROM_CEn, ROM_OEn, ROM_WEn, FRAM_CEn  out  1  memory controls, active low.
- ROM_BUSY  out  1  high while a Flash program is in progress.

## Operation
- sel = ~SLT_SLTSL & SW_ROMenable. wr = sel & ~SLT_WEn. wr_d = wr registered. wr_rise = wr & ~wr_d. There is exactly one register event per bus write.
- Window n = SLT_A[15:13] − 2, n = 0..3. The control region of window n is its lower 4 KB (A[12]=0).
- On wr_rise in the control region of window 1..3 (window 0 too if BANK0_WR=1 and flash_mode=0):
  - pend_val ← D[BANK_BITS-1:0] and pend_win ← n.
  - ram_sel ← D[6] (window 3, MRAM_EN builds only).
  - flash_mode ← D[7] (window 3 only).
  - ram_sel and flash_mode update immediately. A new write overwrites the pending value and restarts the delay count.
- Commit: dcnt loads COMMIT_DELAY on capture and decrements each clock while ROM_BUSY=0. When dcnt=0 and a write is pending, bank[pend_win] ← pend_val and the pending flag clears. With COMMIT_DELAY=0 the commit happens on the capture edge.
- ROM_BA = bank[n] for an addressed window. With flash_mode=1, window 0 overrides: A[12]=0 → 1, A[12]=1 → 2. Outside 4000h–BFFFh, ROM_BA = 0.
- Memory controls:
  - ROM_WEn = SLT_WEn.
  - ROM_OEn = SLT_RDn | ~inwin.
  - ROM_CEn = ~sel | ~inwin | ramhit.
  - FRAM_CEn = ~(sel & ramhit).
  - ramhit = ram_sel & window 3 & (A[12]=1 | SLT_WEn=1). Writes to A000h–AFFFh stay register writes.
- Flash FSM. It advances on wr_rise in window 0 only, and only while flash_mode=1, except the PGM step noted below.
  - IDLE → U1 on D=AAh with A[15:12]=5.
  - U1 → U2 on D=55h with A[15:12]=4; any other window-0 write → IDLE.
  - U2 → PGM on D=A0h; any other window-0 write → IDLE.
  - PGM → BUSY on any wr_rise with inwin=1 (any window), loading bcnt=BUSY_CYCLES.
  - BUSY: bcnt decrements each clock; at bcnt=1 → IDLE. Writes in BUSY are not tracked, but register captures still occur.
  - ROM_BUSY = (state==BUSY).
  - flash_mode cleared while the FSM is not IDLE → IDLE next clock.

## Timing
- Reset (synchronous, SLT_RESET=1 at edge) sets: bank[n]=n, pending cleared, dcnt=0, wr_d=0, flash_mode=0, ram_sel=0, FSM IDLE, bcnt=0, ROM_BUSY=0. Combinational outputs follow from these values.
- Commit latency from the wr_rise edge is COMMIT_DELAY+1 rising edges until the new ROM_BA is visible, extended by every clock spent in BUSY.
- A write held low for multiple clocks captures once. Back-to-back writes need SLT_WEn high for at least 1 sampled clock between them.
- A reset during BUSY or with a pending commit drops the pending value and releases ROM_BUSY on the same edge.
- Counters saturate at 0. There is no wrap-around.

## Configuration
- MRAM_EN defined: ram_sel, ramhit and FRAM_CEn are active as above, and D[6] of a window-3 write selects MRAM.
- MRAM_EN undefined: ram_sel is tied 0, FRAM_CEn is constant 1, ROM_CEn ignores ramhit, and D[6] is ignored.

## Test plan
- Reset, then read 4000h/6000h/8000h/A000h → ROM_BA = 0/1/2/3, ROM_BUSY=0.
- COMMIT_DELAY=1: write 05h to 6000h with SLT_WEn low for 3 clocks → one capture; ROM_BA on 6xxxh reads = 5 exactly 2 edges after wr_rise.
- Write 80h to A000h, then AAh@5555h, 55h@4AAAh, A0h@5555h, data@6123h → ROM_BUSY high for BUSY_CYCLES=12 clocks. A write of 07h to 8000h issued during BUSY commits only after ROM_BUSY falls + COMMIT_DELAY.
- Flash mode on: AAh@5xxxh then 12h@4xxxh → FSM back to IDLE, and the following A0h@5xxxh does not raise ROM_BUSY.
- MRAM_EN: write 40h to A000h, read B000h → FRAM_CEn=0, ROM_CEn=1; read A000h → FRAM_CEn=0; write to A000h → register capture, FRAM_CEn=1.
- Assert SLT_RESET mid-BUSY with a pending write → ROM_BUSY=0 next edge, banks back to 0/1/2/3.
